// File: rtl/carryskip_pipe_adder.sv
// Pipelined carry-skip adder/subtractor. WIDTH is split into STAGES register-separated
// segments of BLOCK-bit ripple groups with skip muxes; valid/ready handshake with full-pipe stall.
module carryskip_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG    = WIDTH / STAGES;
  localparam int unsigned GROUPS = SEG / BLOCK;

  if ((STAGES == 0) || (BLOCK == 0) || ((WIDTH % (STAGES * BLOCK)) != 0)) begin : g_bad_cfg
    $error("carryskip_pipe_adder: WIDTH must be a multiple of STAGES*BLOCK");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction is folded in at entry: invert b, force carry-in to 1.
  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub | cin;
  end

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // One segment: ripple inside each group, skip mux selects the group carry-in when all bits propagate.
  function automatic logic [SEG:0] skip_seg(input logic [SEG-1:0] x,
                                            input logic [SEG-1:0] y,
                                            input logic           ci);
    logic [SEG-1:0] s;
    logic           c;
    logic           r;
    s = '0;
    c = ci;
    for (int g = 0; g < int'(GROUPS); g++) begin
      r = c;
      for (int i = 0; i < int'(BLOCK); i++) begin
        s[g*BLOCK+i] = x[g*BLOCK+i] ^ y[g*BLOCK+i] ^ r;
        r = (x[g*BLOCK+i] & y[g*BLOCK+i]) | (r & (x[g*BLOCK+i] ^ y[g*BLOCK+i]));
      end
      c = (&(x[g*BLOCK +: BLOCK] ^ y[g*BLOCK +: BLOCK])) ? c : r;
    end
    return {c, s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned IN_W  = WIDTH - k * SEG;
    localparam int unsigned OUT_W = (k + 1) * SEG;

    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic             c_in;
    logic             v_in;
    logic [SEG:0]     seg_r;
    logic [OUT_W-1:0] s_new;
    logic             v_d, v_q;
    logic             c_d, c_q;
    logic [OUT_W-1:0] s_d, s_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_in  = a;
        b_in  = b_eff;
        c_in  = c_eff;
        v_in  = in_valid;
        s_new = seg_r[SEG-1:0];
      end
    end else begin : g_src
      // Unprocessed operand bits and the carry arrive from the previous stage register.
      always_comb begin
        a_in  = g_stg[k-1].g_pass.a_q;
        b_in  = g_stg[k-1].g_pass.b_q;
        c_in  = g_stg[k-1].c_q;
        v_in  = g_stg[k-1].v_q;
        s_new = {seg_r[SEG-1:0], g_stg[k-1].s_q};
      end
    end

    assign seg_r = skip_seg(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

    always_comb begin
      v_d = stall ? v_q : v_in;
      c_d = stall ? c_q : seg_r[SEG];
      s_d = stall ? s_q : s_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_pass
      logic [IN_W-SEG-1:0] a_d, a_q;
      logic [IN_W-SEG-1:0] b_d, b_q;

      always_comb begin
        a_d = stall ? a_q : a_in[IN_W-1:SEG];
        b_d = stall ? b_q : b_in[IN_W-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;

      // Carry into the MSB is recovered as a^b^s at the MSB; overflow is that XOR carry-out.
      always_comb begin
        ovf_d = stall ? ovf_q
                      : (a_in[SEG-1] ^ b_in[SEG-1] ^ seg_r[SEG-1] ^ seg_r[SEG]);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  always_comb begin
    out_valid = g_stg[STAGES-1].v_q;
    sum       = g_stg[STAGES-1].s_q;
    cout      = g_stg[STAGES-1].c_q;
    ovf       = g_stg[STAGES-1].g_last.ovf_q;
  end

endmodule

// File: tb/tb_carryskip_pipe_adder.sv
// Bench for carryskip_pipe_adder: directed vectors, backpressure, mid-flight reset and
// random traffic on three configurations, all scored against an arithmetic reference.
module tb_carryskip_pipe_adder;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        of;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cin_i, sub_i;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, co0, of0;
  logic [31:0] a0, b0, sum0;

  logic        in_valid1, out_ready1;
  logic [63:0] a1, b1;
  logic        in_ready1, out_valid1, co1, of1;
  logic        in_ready2, out_valid2, co2, of2;
  logic [63:0] sum1, sum2;

  int checks = 0;
  int errors = 0;
  int npop[3] = '{0, 0, 0};
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  carryskip_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
    .cin(cin_i), .sub(sub_i), .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0),
    .cout(co0), .ovf(of0));

  carryskip_pipe_adder #(.WIDTH(64), .BLOCK(8), .STAGES(4)) u64s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin_i), .sub(sub_i), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .cout(co1), .ovf(of1));

  carryskip_pipe_adder #(.WIDTH(64), .BLOCK(8), .STAGES(1)) u64s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready2), .a(a1), .b(b1),
    .cin(cin_i), .sub(sub_i), .out_valid(out_valid2), .out_ready(out_ready1), .sum(sum2),
    .cout(co2), .ovf(of2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic c, input logic s, input int w);
    logic [64:0] mask, bb, tot;
    exp_t e;
    mask = (65'd1 << w) - 65'd1;
    bb   = s ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
    tot  = ({1'b0, x} & mask) + bb + (s ? 65'd1 : {64'd0, c});
    e.s  = tot[63:0] & mask[63:0];
    e.co = tot[w];
    e.of = (x[w-1] == bb[w-1]) && (tot[w-1] != x[w-1]);
    return e;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v, m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v = {$urandom, $urandom};
    case ($urandom % 8)
      0: v = '0;
      1: v = '1;
      2: v = m >> 1;
      3: v = ~(m >> 1);
      default: ;
    endcase
    return v & m;
  endfunction

  function automatic int qn(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qf(input int id);
    case (id)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int id);
    case (id)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
    npop[id]++;
  endtask

  task automatic mon_out(input int id, input logic ov, input logic ordy, input logic [63:0] s,
                         input logic co, input logic of);
    exp_t e;
    if (ov) begin
      if (qn(id) == 0) check($sformatf("u%0d_extra_out", id), 64'(ov), 64'(0));
      else begin
        e = qf(id);
        check($sformatf("u%0d_sum", id), s, e.s);
        check($sformatf("u%0d_cout", id), 64'(co), 64'(e.co));
        check($sformatf("u%0d_ovf", id), 64'(of), 64'(e.of));
        if (ordy) qpop(id);
      end
    end
  endtask

  // Mid-cycle scoreboard: values seen here are what the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      mon_out(0, out_valid0, out_ready0, {32'h0, sum0}, co0, of0);
      mon_out(1, out_valid1, out_ready1, sum1, co1, of1);
      mon_out(2, out_valid2, out_ready1, sum2, co2, of2);
      if (in_valid0 && in_ready0) q0.push_back(model({32'h0, a0}, {32'h0, b0}, cin_i, sub_i, 32));
      if (in_valid1 && in_ready1) q1.push_back(model(a1, b1, cin_i, sub_i, 64));
      if (in_valid1 && in_ready2) q2.push_back(model(a1, b1, cin_i, sub_i, 64));
    end
  end

  task automatic send0(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
    bit ok = 1'b0;
    a0 = x; b0 = y; cin_i = c; sub_i = s; in_valid0 = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = in_ready0;
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    if (!ok) check("send0_timeout", 64'(in_ready0), 64'(1));
  endtask

  task automatic dir0(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                      input logic [31:0] es, input logic ec, input logic eo);
    int n = 0;
    send0(x, y, c, s);
    while (!out_valid0 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("u32_latency", 64'(n), 64'(1));
    check("u32_dir_sum", {32'h0, sum0}, {32'h0, es});
    check("u32_dir_cout", 64'(co0), 64'(ec));
    check("u32_dir_ovf", 64'(of0), 64'(eo));
  endtask

  task automatic dir1(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s,
                      input logic [63:0] es, input logic ec, input logic eo);
    int n = 0;
    bit d1 = 1'b0, d2 = 1'b0;
    a1 = x; b1 = y; cin_i = c; sub_i = s; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    while (!(d1 && d2) && n < 10) begin
      if (!d1 && out_valid1) begin
        d1 = 1'b1;
        check("u64s4_latency", 64'(n), 64'(3));
        check("u64s4_dir_sum", sum1, es);
        check("u64s4_dir_cout", 64'(co1), 64'(ec));
        check("u64s4_dir_ovf", 64'(of1), 64'(eo));
      end
      if (!d2 && out_valid2) begin
        d2 = 1'b1;
        check("u64s1_latency", 64'(n), 64'(0));
        check("u64s1_dir_sum", sum2, es);
        check("u64s1_dir_cout", 64'(co2), 64'(ec));
        check("u64s1_dir_ovf", 64'(of2), 64'(eo));
      end
      if (!(d1 && d2)) begin
        @(posedge clk); #1; n++;
      end
    end
    check("u64_dir_seen", {62'h0, d1, d2}, 64'h3);
  endtask

  task automatic drain(input int id);
    int n = 0;
    while (qn(id) != 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("u%0d_drain", id), 64'(qn(id)), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int p0;
    rst_n = 1'b0; cin_i = 1'b0; sub_i = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b1; a0 = '0; b0 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
    #1;
    check("rst_out_valid", 64'(out_valid0), 64'(0));
    check("rst_sum", {32'h0, sum0}, 64'h0);
    check("rst_cout", 64'(co0), 64'(0));
    check("rst_ovf", 64'(of0), 64'(0));
    check("rst_in_ready", 64'(in_ready0), 64'(1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    dir0(32'h001F001F, 32'h000C001F, 1'b0, 1'b0, 32'h002B003E, 1'b0, 1'b0);
    dir0(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    dir0(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    dir0(32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
    dir0(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    drain(0);

    // Four adds with the consumer stalled for three cycles.
    p0 = npop[0];
    out_ready0 = 1'b0;
    send0($urandom, $urandom, 1'b0, 1'b0);
    send0($urandom, $urandom, 1'b1, 1'b0);
    a0 = $urandom; b0 = $urandom; cin_i = 1'b0; sub_i = 1'b0; in_valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("bp_in_ready", 64'(in_ready0), 64'(0));
      @(posedge clk); #1;
    end
    out_ready0 = 1'b1;
    send0(a0, b0, 1'b0, 1'b0);
    send0($urandom, $urandom, 1'b1, 1'b0);
    drain(0);
    check("bp_delivered", 64'(npop[0] - p0), 64'(4));
    check("bp_idle_valid", 64'(out_valid0), 64'(0));

    // Random mixed add/sub with random backpressure; producer holds until accepted.
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk); acc = in_valid0 && in_ready0;
      @(posedge clk); #1;
      if (acc || !in_valid0) begin
        in_valid0 = ($urandom % 4) != 0;
        a0 = 32'(pick(32)); b0 = 32'(pick(32));
        cin_i = 1'($urandom); sub_i = 1'($urandom);
      end
      out_ready0 = ($urandom % 3) != 0;
    end
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    drain(0);

    // Reset with two transactions in flight.
    out_ready0 = 1'b0;
    send0(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    send0(32'h33333333, 32'h44444444, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid0), 64'(0));
    check("midrst_sum", {32'h0, sum0}, 64'h0);
    check("midrst_cout", 64'(co0), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("postrst_stale", 64'(out_valid0), 64'(0));
    end
    @(posedge clk); #1;
    dir0(32'h001F001F, 32'h000C001F, 1'b0, 1'b0, 32'h002B003E, 1'b0, 1'b0);
    drain(0);

    dir1(64'h001F001F, 64'h000C001F, 1'b0, 1'b0, 64'h002B003E, 1'b0, 1'b0);
    dir1('1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    dir1(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0);
    dir1(64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1);

    for (int cyc = 0; cyc < 150; cyc++) begin
      @(posedge clk); #1;
      in_valid1 = ($urandom % 4) != 0;
      a1 = pick(64); b1 = pick(64);
      cin_i = 1'($urandom); sub_i = 1'($urandom);
      out_ready1 = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    drain(1);
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
